// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the 5-stage MIPS32 core: ID decode, ID/EX..MEM/WB control
// registers, load-use/branch hazard detection, forwarding selects and PC/flush control.
module pipe_ctrl_unit #(
    parameter int unsigned REGW     = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      op,
    input  logic [5:0]      func,
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rt,
    input  logic [REGW-1:0] rd,
    input  logic            id_valid,
    input  logic            eq,
    input  logic            mem_ready,
    output logic            stall,
    output logic            hold,
    output logic            flush_if,
    output logic [1:0]      pc_sel,
    output logic            id_fwda,
    output logic            id_fwdb,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic [2:0]      ex_aluc,
    output logic            ex_alusrcb,
    output logic            mem_read,
    output logic            mem_write,
    output logic            wb_writereg,
    output logic            wb_mem2reg,
    output logic [REGW-1:0] wb_dest
);

    localparam int unsigned ALUW = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2a;

    typedef struct packed {
        logic            valid;
        logic            wreg;
        logic            mrd;
        logic            mwr;
        logic [ALUW-1:0] aluc;
        logic            alusrcb;
        logic [REGW-1:0] dest;
        logic [REGW-1:0] rs;
        logic [REGW-1:0] rt;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic            wreg;
        logic            mrd;
        logic            mwr;
        logic [REGW-1:0] dest;
    } exmem_t;

    typedef struct packed {
        logic            valid;
        logic            wreg;
        logic            mem2reg;
        logic [REGW-1:0] dest;
    } memwb_t;

    idex_t  dec;
    idex_t  idex;
    exmem_t exmem;
    memwb_t memwb;

    logic is_r;
    logic is_beq;
    logic is_j;
    logic use_rs;
    logic use_rt;
    logic load_use;
    logic br_haz;

    // ID decode; unsupported encodings and bubbles leave every control bit clear
    always_comb begin
        dec    = '0;
        is_r   = 1'b0;
        is_beq = 1'b0;
        is_j   = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        if (id_valid) begin
            case (op)
                OP_RTYPE: begin
                    case (func)
                        F_ADD:   begin is_r = 1'b1; dec.aluc = 3'b010; end
                        F_SUB:   begin is_r = 1'b1; dec.aluc = 3'b110; end
                        F_AND:   begin is_r = 1'b1; dec.aluc = 3'b000; end
                        F_OR:    begin is_r = 1'b1; dec.aluc = 3'b001; end
                        F_SLT:   begin is_r = 1'b1; dec.aluc = 3'b111; end
                        default: ;
                    endcase
                end
                OP_LW: begin
                    dec.mrd     = 1'b1;
                    dec.aluc    = 3'b010;
                    dec.alusrcb = 1'b1;
                    dec.wreg    = 1'b1;
                    dec.dest    = rt;
                    use_rs      = 1'b1;
                end
                OP_SW: begin
                    dec.mwr     = 1'b1;
                    dec.aluc    = 3'b010;
                    dec.alusrcb = 1'b1;
                    use_rs      = 1'b1;
                    use_rt      = 1'b1;
                end
                OP_BEQ: begin
                    is_beq = 1'b1;
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
                OP_J:    is_j = 1'b1;
                default: ;
            endcase
        end
        if (is_r) begin
            dec.wreg = 1'b1;
            dec.dest = rd;
            use_rs   = 1'b1;
            use_rt   = 1'b1;
        end
        if (ZERO_REG != 0 && dec.dest == '0) begin
            dec.wreg = 1'b0;
        end
        if (!dec.wreg) begin
            dec.dest = '0;
        end
        dec.valid = id_valid;
        dec.rs    = rs;
        dec.rt    = rt;
    end

    // Hazard detection; a memory wait overrides everything
    always_comb begin
        load_use = idex.valid && idex.mrd && idex.wreg &&
                   ((use_rs && idex.dest == rs) || (use_rt && idex.dest == rt));
        br_haz   = is_beq &&
                   ((idex.wreg && (idex.dest == rs || idex.dest == rt)) ||
                    (exmem.mrd && exmem.wreg && (exmem.dest == rs || exmem.dest == rt)));
        hold     = exmem.valid && (exmem.mrd || exmem.mwr) && !mem_ready;
        stall    = hold || load_use || br_haz;
    end

    // Forwarding selects and PC redirect
    always_comb begin
        fwda     = 2'd0;
        fwdb     = 2'd0;
        pc_sel   = 2'd0;
        flush_if = 1'b0;
        if (idex.valid) begin
            if (exmem.wreg && !exmem.mrd && exmem.dest == idex.rs)      fwda = 2'd1;
            else if (memwb.wreg && memwb.dest == idex.rs)               fwda = 2'd2;
            if (exmem.wreg && !exmem.mrd && exmem.dest == idex.rt)      fwdb = 2'd1;
            else if (memwb.wreg && memwb.dest == idex.rt)               fwdb = 2'd2;
        end
        id_fwda = is_beq && exmem.wreg && !exmem.mrd && exmem.dest == rs;
        id_fwdb = is_beq && exmem.wreg && !exmem.mrd && exmem.dest == rt;
        if (!stall) begin
            if (is_j) begin
                pc_sel   = 2'd2;
                flush_if = 1'b1;
            end else if (is_beq && eq) begin
                pc_sel   = 2'd1;
                flush_if = 1'b1;
            end
        end
    end

    // Stage registers; on hold the front stays put and MEM/WB takes a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else if (hold) begin
            memwb <= '0;
        end else begin
            memwb.valid   <= exmem.valid;
            memwb.wreg    <= exmem.wreg;
            memwb.mem2reg <= exmem.mrd;
            memwb.dest    <= exmem.dest;
            exmem.valid   <= idex.valid;
            exmem.wreg    <= idex.wreg;
            exmem.mrd     <= idex.mrd;
            exmem.mwr     <= idex.mwr;
            exmem.dest    <= idex.dest;
            idex          <= stall ? '0 : dec;
        end
    end

    assign ex_aluc     = idex.aluc;
    assign ex_alusrcb  = idex.alusrcb;
    assign mem_read    = exmem.mrd;
    assign mem_write   = exmem.mwr;
    assign wb_writereg = memwb.valid && memwb.wreg;
    assign wb_mem2reg  = memwb.mem2reg;
    assign wb_dest     = memwb.dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed-vector bench for pipe_ctrl_unit; a second instance with ZERO_REG = 0
// covers the register-0 behaviour.
module tb_pipe_ctrl_unit;

    localparam int unsigned REGW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [5:0]      op, func;
    logic [REGW-1:0] rs, rt, rd;
    logic            id_valid, eq, mem_ready;

    logic            stall, hold, flush_if, id_fwda, id_fwdb;
    logic [1:0]      pc_sel, fwda, fwdb;
    logic [2:0]      ex_aluc;
    logic            ex_alusrcb, mem_read, mem_write, wb_writereg, wb_mem2reg;
    logic [REGW-1:0] wb_dest;

    logic            z_stall, z_hold, z_flush_if, z_id_fwda, z_id_fwdb;
    logic [1:0]      z_pc_sel, z_fwda, z_fwdb;
    logic [2:0]      z_ex_aluc;
    logic            z_ex_alusrcb, z_mem_read, z_mem_write, z_wb_writereg, z_wb_mem2reg;
    logic [REGW-1:0] z_wb_dest;

    int nvec = 0;
    int nmis = 0;
    int pulses;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REGW(REGW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .id_valid(id_valid), .eq(eq), .mem_ready(mem_ready),
        .stall(stall), .hold(hold), .flush_if(flush_if), .pc_sel(pc_sel),
        .id_fwda(id_fwda), .id_fwdb(id_fwdb), .fwda(fwda), .fwdb(fwdb),
        .ex_aluc(ex_aluc), .ex_alusrcb(ex_alusrcb), .mem_read(mem_read),
        .mem_write(mem_write), .wb_writereg(wb_writereg), .wb_mem2reg(wb_mem2reg),
        .wb_dest(wb_dest)
    );

    pipe_ctrl_unit #(.REGW(REGW), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .id_valid(id_valid), .eq(eq), .mem_ready(mem_ready),
        .stall(z_stall), .hold(z_hold), .flush_if(z_flush_if), .pc_sel(z_pc_sel),
        .id_fwda(z_id_fwda), .id_fwdb(z_id_fwdb), .fwda(z_fwda), .fwdb(z_fwdb),
        .ex_aluc(z_ex_aluc), .ex_alusrcb(z_ex_alusrcb), .mem_read(z_mem_read),
        .mem_write(z_mem_write), .wb_writereg(z_wb_writereg), .wb_mem2reg(z_wb_mem2reg),
        .wb_dest(z_wb_dest)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv_r(input logic [5:0] f, input int s, input int t, input int d);
        id_valid = 1'b1; op = 6'h00; func = f;
        rs = REGW'(s); rt = REGW'(t); rd = REGW'(d);
    endtask

    task automatic drv_i(input logic [5:0] o, input int s, input int t);
        id_valid = 1'b1; op = o; func = 6'h00;
        rs = REGW'(s); rt = REGW'(t); rd = '0;
    endtask

    task automatic drv_nop();
        id_valid = 1'b0; op = '0; func = '0; rs = '0; rt = '0; rd = '0; eq = 1'b0;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drv_nop();
        repeat (4) adv();
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1;
        drv_nop();
        repeat (2) adv();
        smp();
        check_eq("rst_stall", 32'(stall), 0);
        check_eq("rst_wb", 32'(wb_writereg), 0);
        rst = 1'b0;
        adv();

        // reset asserted mid-hold clears everything at once
        drv_i(6'h2b, 1, 2);
        smp(); check_eq("sw_stall", 32'(stall), 0);
        adv();
        drv_nop();
        smp();
        check_eq("sw_aluc", 32'(ex_aluc), 3'b010);
        check_eq("sw_srcb", 32'(ex_alusrcb), 1);
        adv();
        mem_ready = 1'b0;
        smp();
        check_eq("pre_hold", 32'(hold), 1);
        check_eq("pre_memw", 32'(mem_write), 1);
        rst = 1'b1;
        #1;
        check_eq("arst_hold", 32'(hold), 0);
        check_eq("arst_stall", 32'(stall), 0);
        check_eq("arst_memw", 32'(mem_write), 0);
        check_eq("arst_pcsel", 32'(pc_sel), 0);
        mem_ready = 1'b1;
        adv();
        rst = 1'b0;

        drv_r(6'h20, 1, 2, 3);
        smp(); check_eq("post_rst_stall", 32'(stall), 0);
        adv(); drv_nop(); adv(); adv();
        smp();
        check_eq("rst_add_wb", 32'(wb_writereg), 1);
        check_eq("rst_add_dest", 32'(wb_dest), 3);
        adv(); smp();
        check_eq("rst_add_once", 32'(wb_writereg), 0);
        drain();

        // ALU chain with EX forwarding
        drv_r(6'h20, 1, 2, 3); smp(); check_eq("alu_s0", 32'(stall), 0); adv();
        drv_r(6'h22, 3, 5, 4); smp(); check_eq("alu_s1", 32'(stall), 0); adv();
        drv_r(6'h25, 5, 3, 6); smp();
        check_eq("alu_s2", 32'(stall), 0);
        check_eq("sub_fwda", 32'(fwda), 1);
        check_eq("sub_fwdb", 32'(fwdb), 0);
        check_eq("sub_aluc", 32'(ex_aluc), 3'b110);
        adv();
        drv_nop(); smp();
        check_eq("or_fwda", 32'(fwda), 0);
        check_eq("or_fwdb", 32'(fwdb), 2);
        check_eq("or_aluc", 32'(ex_aluc), 3'b001);
        check_eq("add_wb_dest", 32'(wb_dest), 3);
        drain();

        // slt and an unsupported R-type function
        drv_r(6'h2a, 1, 2, 8); adv();
        drv_r(6'h08, 1, 2, 9); smp(); check_eq("slt_aluc", 32'(ex_aluc), 3'b111); adv();
        drv_nop(); smp(); check_eq("bad_aluc", 32'(ex_aluc), 0); adv(); adv();
        smp(); check_eq("bad_nowb", 32'(wb_writereg), 0);
        drain();

        // load-use
        drv_i(6'h23, 1, 2); smp(); check_eq("lu_s0", 32'(stall), 0); adv();
        drv_r(6'h20, 2, 2, 4); smp(); check_eq("lu_s1", 32'(stall), 1); adv();
        smp(); check_eq("lu_s2", 32'(stall), 0); adv();
        drv_nop(); smp();
        check_eq("lu_fwda", 32'(fwda), 2);
        check_eq("lu_fwdb", 32'(fwdb), 2);
        check_eq("lu_aluc", 32'(ex_aluc), 3'b010);
        check_eq("lu_m2r", 32'(wb_mem2reg), 1);
        drain();

        // beq after ALU op, taken
        drv_r(6'h20, 1, 1, 5); adv();
        drv_i(6'h04, 5, 0); eq = 1'b1; smp();
        check_eq("bq_s1", 32'(stall), 1);
        check_eq("bq_pc1", 32'(pc_sel), 0);
        check_eq("bq_fl1", 32'(flush_if), 0);
        adv(); smp();
        check_eq("bq_s2", 32'(stall), 0);
        check_eq("bq_idfa", 32'(id_fwda), 1);
        check_eq("bq_idfb", 32'(id_fwdb), 0);
        check_eq("bq_pc2", 32'(pc_sel), 1);
        check_eq("bq_fl2", 32'(flush_if), 1);
        adv();
        drv_nop(); smp(); check_eq("bq_fl3", 32'(flush_if), 0);
        drv_i(6'h02, 0, 0); #1;
        check_eq("j_pc", 32'(pc_sel), 2);
        check_eq("j_fl", 32'(flush_if), 1);
        drain();

        // beq after lw: two stall cycles
        drv_i(6'h23, 1, 5); adv();
        drv_i(6'h04, 5, 1); smp(); check_eq("bl_s1", 32'(stall), 1); adv();
        smp(); check_eq("bl_s2", 32'(stall), 1); adv();
        smp(); check_eq("bl_s3", 32'(stall), 0); check_eq("bl_pc", 32'(pc_sel), 0);
        drain();

        // memory wait: three cycles of mem_ready low with sw in EX/MEM
        drv_r(6'h20, 1, 2, 7); adv();
        drv_i(6'h2b, 1, 7); adv();
        drv_nop(); adv();
        pulses = 0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            if (wb_writereg) pulses++;
            check_eq($sformatf("mw_hold%0d", i), 32'(hold), 1);
            check_eq($sformatf("mw_stall%0d", i), 32'(stall), 1);
            check_eq($sformatf("mw_memw%0d", i), 32'(mem_write), 1);
            adv();
        end
        mem_ready = 1'b1;
        smp();
        if (wb_writereg) pulses++;
        check_eq("mw_release", 32'(hold), 0);
        check_eq("mw_memw3", 32'(mem_write), 1);
        adv(); smp();
        if (wb_writereg) pulses++;
        check_eq("mw_memw4", 32'(mem_write), 0);
        check_eq("mw_pulses", 32'(pulses), 1);
        drain();

        // register 0 as destination
        drv_r(6'h20, 1, 2, 0); adv();
        drv_r(6'h20, 0, 0, 3); smp();
        check_eq("z1_stall", 32'(stall), 0);
        check_eq("z0_stall", 32'(z_stall), 0);
        adv();
        drv_nop(); smp();
        check_eq("z1_fwda", 32'(fwda), 0);
        check_eq("z1_fwdb", 32'(fwdb), 0);
        check_eq("z0_fwda", 32'(z_fwda), 1);
        check_eq("z0_fwdb", 32'(z_fwdb), 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
